// File: rtl/fast_axis_shell.sv
// ---------------------------------------------------------------------------
// fast_axis_shell
// AXI4-Stream wrapper for valid-only pixel cores (FAST and successors).
// The slave side tracks the frame position from the configured size plus
// TUSER/TLAST and strobes each pixel into the core one cycle after it is
// accepted. A tag FIFO carries {sof,eol} alongside the core's latency. Core
// results are joined with their tags into a first-word-fall-through result
// FIFO that drives the master side. Credit counting (results buffered plus
// pixels still inside the core) gates s_tready, so the result FIFO can never
// overflow and backpressure reaches all the way upstream.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   cfg_width, cfg_height    frame size, sampled on each accepted SOF beat
//   s_tdata/tvalid/tuser/tlast/tready   input stream (tuser=SOF, tlast=EOL)
//   core_data_en, core_data  registered pixel strobe to the core
//   core_valid, core_result  core result strobe, one per pixel, in order
//   m_tdata/tvalid/tuser/tlast/tready   output stream
//   err_sof                  pulse: beat without SOF outside a frame, or SOF mid-frame
//   err_eol                  pulse: TLAST disagrees with the x counter
// ---------------------------------------------------------------------------
module fast_axis_shell #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 64,
   parameter int DIM_W      = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tuser,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic              core_data_en,
   output logic [DATA_W-1:0] core_data,
   input  logic              core_valid,
   input  logic [DATA_W-1:0] core_result,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tuser,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic              err_sof,
   output logic              err_eol
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

   typedef enum logic {WAIT_SOF = 1'b0, IN_FRAME = 1'b1} state_t;

   state_t            r_state, w_state_next;
   logic [DIM_W-1:0]  r_x, r_y, r_w, r_h;
   logic [DIM_W-1:0]  w_x_next, w_y_next, w_cfg_w, w_cfg_h;
   logic [DIM_W-1:0]  w_cur_x, w_cur_y, w_cur_w, w_cur_h;
   logic              w_accept, w_fwd, w_start, w_err_sof, w_err_eol;
   logic              w_tag_sof, w_tag_eol, w_last_beat;

   logic              r_core_en;
   logic [DATA_W-1:0] r_core_data;
   logic              r_err_sof, r_err_eol;

   logic [1:0]        r_tag_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_tag_wp, r_tag_rp;
   logic [1:0]        w_tag_head;

   logic [DATA_W+1:0] r_res_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_res_wp, r_res_rp;
   logic [CW-1:0]     r_res_cnt, r_inflight;
   logic [DATA_W+1:0] w_res_head;
   logic              w_pop;
   logic [CW:0]       w_occupancy;

   // Every accepted pixel owns one slot until its result leaves the shell.
   assign w_occupancy = {1'b0, r_res_cnt} + {1'b0, r_inflight};
   assign s_tready    = w_occupancy < DEPTH_L;
   assign w_accept    = s_tvalid & s_tready;

   // A zero dimension would make the frame unterminated; treat it as 1.
   assign w_cfg_w = (cfg_width  == '0) ? DIM_W'(1) : cfg_width;
   assign w_cfg_h = (cfg_height == '0) ? DIM_W'(1) : cfg_height;

   always_comb begin
      w_state_next = r_state;
      w_fwd        = 1'b0;
      w_start      = 1'b0;
      w_err_sof    = 1'b0;
      w_err_eol    = 1'b0;
      case (r_state)
         WAIT_SOF: begin
            if (w_accept) begin
               if (s_tuser) begin
                  w_start = 1'b1;
                  w_fwd   = 1'b1;
               end else begin
                  w_err_sof = 1'b1;
               end
            end
         end
         IN_FRAME: begin
            if (w_accept) begin
               w_fwd = 1'b1;
               // SOF inside a frame restarts the frame at this beat; it is
               // only an error when it arrives away from (0,0).
               if (s_tuser) begin
                  w_start   = 1'b1;
                  w_err_sof = (r_x != '0) || (r_y != '0);
               end
            end
         end
         default: w_state_next = WAIT_SOF;
      endcase

      // Position and size that apply to the beat being accepted now.
      w_cur_x     = w_start ? '0 : r_x;
      w_cur_y     = w_start ? '0 : r_y;
      w_cur_w     = w_start ? w_cfg_w : r_w;
      w_cur_h     = w_start ? w_cfg_h : r_h;
      w_tag_sof   = (w_cur_x == '0) && (w_cur_y == '0);
      w_tag_eol   = (w_cur_x == w_cur_w - DIM_W'(1));
      w_last_beat = w_tag_eol && (w_cur_y == w_cur_h - DIM_W'(1));

      w_x_next = r_x;
      w_y_next = r_y;
      if (w_fwd) begin
         // Counters stay authoritative; TLAST is only checked.
         w_err_eol = (s_tlast != w_tag_eol);
         if (w_tag_eol) begin
            w_x_next = '0;
            w_y_next = w_last_beat ? '0 : w_cur_y + DIM_W'(1);
         end else begin
            w_x_next = w_cur_x + DIM_W'(1);
            w_y_next = w_cur_y;
         end
         w_state_next = w_last_beat ? WAIT_SOF : IN_FRAME;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= WAIT_SOF;
         r_x         <= '0;
         r_y         <= '0;
         r_w         <= DIM_W'(1);
         r_h         <= DIM_W'(1);
         r_core_en   <= 1'b0;
         r_core_data <= '0;
         r_err_sof   <= 1'b0;
         r_err_eol   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_x       <= w_x_next;
         r_y       <= w_y_next;
         if (w_start) begin
            r_w <= w_cfg_w;
            r_h <= w_cfg_h;
         end
         r_core_en <= w_fwd;
         if (w_fwd) begin
            r_core_data <= s_tdata;
         end
         r_err_sof <= w_err_sof;
         r_err_eol <= w_err_eol;
      end
   end

   // Storage has no reset: pointers and counts define what is valid.
   // Reads are asynchronous so the FIFO head is visible without a read stage.
   always_ff @(posedge clk) begin
      if (w_fwd) begin
         r_tag_mem[r_tag_wp] <= {w_tag_sof, w_tag_eol};
      end
      if (core_valid) begin
         r_res_mem[r_res_wp] <= {w_tag_head, core_result};
      end
   end

   assign w_tag_head = r_tag_mem[r_tag_rp];
   assign w_res_head = r_res_mem[r_res_rp];
   assign w_pop      = m_tvalid & m_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_wp   <= '0;
         r_tag_rp   <= '0;
         r_res_wp   <= '0;
         r_res_rp   <= '0;
         r_res_cnt  <= '0;
         r_inflight <= '0;
      end else begin
         if (w_fwd) begin
            r_tag_wp <= r_tag_wp + AW'(1);
         end
         if (core_valid) begin
            r_tag_rp <= r_tag_rp + AW'(1);
            r_res_wp <= r_res_wp + AW'(1);
         end
         if (w_pop) begin
            r_res_rp <= r_res_rp + AW'(1);
         end
         case ({w_fwd, core_valid})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
         case ({core_valid, w_pop})
            2'b10:   r_res_cnt <= r_res_cnt + CW'(1);
            2'b01:   r_res_cnt <= r_res_cnt - CW'(1);
            default: r_res_cnt <= r_res_cnt;
         endcase
      end
   end

   assign core_data_en = r_core_en;
   assign core_data    = r_core_data;
   assign err_sof      = r_err_sof;
   assign err_eol      = r_err_eol;
   assign m_tvalid     = (r_res_cnt != '0);
   // Gate the head with valid so an empty FIFO presents all-zero outputs.
   assign m_tdata      = m_tvalid ? w_res_head[DATA_W-1:0] : '0;
   assign m_tuser      = m_tvalid & w_res_head[DATA_W+1];
   assign m_tlast      = m_tvalid & w_res_head[DATA_W];

endmodule
